vm_credit_ctrl: RTL
===================

# vm_credit_ctrl

Parametrised credit controller for the vending machine. It holds the running credit total and accepts coins from N coin types. It dispenses one of M items against that credit, and returns change either on request or after an inactivity timeout. It replaces the bare total register with the full insert/select/dispense/return sequence, and sits between the coin/keypad front end and the item/coin actuators.

## Interface
- TOTAL_W, 16, width of credit total; arithmetic saturates below 2^TOTAL_W.
- N_COIN, 3, number of coin types; values come from the package array COIN_VAL, ascending, with COIN_VAL[0] the smallest.
- N_ITEM, 4, number of items; prices come from the package array ITEM_PRICE.
- TIMEOUT, 100, inactivity cycles before automatic change return; must be ≥ 1.
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- i_coin  in  N_COIN  one-hot coin insertion strobe; at most one bit set; sampled each cycle.
- i_select  in  N_ITEM  one-hot item request strobe.
- i_return  in  1  change-return request strobe.
- o_total  out  TOTAL_W  current credit (registered).
- o_available  out  N_ITEM  bit k = (o_total ≥ ITEM_PRICE[k]); derived from the registered total.
- o_item  out  N_ITEM  one-hot dispense pulse, one cycle.
- o_coin_ret  out  N_COIN  one-hot returned-coin pulse, one cycle per coin.
- o_coin_reject  out  1  one-cycle pulse when an inserted coin is refused.
- o_busy  out  1  high while in RETURN.

## Operation
- States: IDLE (total = 0), CREDIT (total > 0), RETURN.
- Multi-hot i_coin or i_select is a protocol error; behaviour is unspecified and the bench must not drive it.
- **Coin accept** (IDLE/CREDIT): the new total is total + COIN_VAL[c], computed in TOTAL_W+1 bits.
  - If the sum exceeds 2^TOTAL_W−1, the coin is refused: o_coin_reject pulses and the total is unchanged.
  - If accepted, IDLE→CREDIT, and the timeout counter reloads to TIMEOUT.
- **Select** (CREDIT): if total ≥ ITEM_PRICE[k], o_item[k] pulses and total −= price.
  - If insufficient, the request is ignored with no pulse.
  - A successful dispense reloads the timeout counter.
- **Coin and select in the same cycle**: the select is judged against the pre-coin total. Both are applied, giving new total = total − price + coin.
  - The overflow check uses this combined result.
- **Return entry** (CREDIT only): i_return, or the timeout counter reaching 0 with total > 0.
  - i_return takes priority over coin and select in the same cycle. Coin and select are then ignored; no reject pulse is issued.
- **RETURN**: each cycle, pulse o_coin_ret for the largest coin with COIN_VAL ≤ total, and subtract its value.
  - Exit to IDLE when total = 0.
  - Exit to IDLE with the remainder retained when total < COIN_VAL[0].
  - i_coin, i_select and i_return are ignored. An inserted coin is rejected, with an o_coin_reject pulse.
- **IDLE**: i_return and i_select are ignored; the timeout counter is held.

## Timing
- All outputs except o_available are registered. A strobe sampled at edge n produces its o_item, o_coin_ret or o_coin_reject pulse, and its updated o_total, at edge n.
- Those values are visible during cycle n+1.
- **Timeout counter**:
  - Decrements once per cycle in CREDIT.
  - The cycle it reads 0, the FSM enters RETURN; with no activity this is TIMEOUT cycles after the last reload.
- **Return latency**:
  - First o_coin_ret pulse comes one cycle after return entry.
  - One coin per cycle after that; o_busy is high for every RETURN cycle.
- **Reset values**: total = 0, state IDLE, counter = TIMEOUT.
  - All pulse outputs and o_busy read 0.
  - o_available reads 1 only for zero-priced items.
- **Reset mid-RETURN**: aborts immediately, with no further coin pulses. The remaining credit is discarded.

## Structure
- Package vending_machine_pkg holds:
  - the state enum (IDLE, CREDIT, RETURN);
  - the COIN_VAL and ITEM_PRICE constant arrays;
  - the default TOTAL_W, N_COIN and N_ITEM values.
- Sub-module vm_change_picker: combinational greedy selector. Input is the total; outputs are a one-hot coin and its value (zero when no coin fits).
- The top module holds the FSM, the total register, the timeout counter and the output pulse registers.

## Test plan
All scenarios use COIN_VAL = {100, 500, 1000} and ITEM_PRICE = {400, 500, 1000, 2000}.
- Insert 500, then 1000 → o_total reads 500, then 1500; o_available = 0111.
- Total 1500, select item 2 → o_item = 0100 for one cycle; o_total = 500. Select item 3 → ignored.
- Total 1500, i_return → o_coin_ret reads 100 (1000 coin), 010 (500 coin); o_busy high for 2 cycles; total 0, IDLE.
- Insert 100, then idle for TIMEOUT cycles → one 100-coin return, exactly TIMEOUT+1 cycles after the insertion edge.
- TOTAL_W = 11, total 1500, insert 1000 → o_coin_reject pulses; total stays 1500.
- Total 400, select item 0 together with inserting 100 in the same cycle → dispense item 0; total = 100.
- Reset asserted mid-RETURN → next cycle total 0, no o_coin_ret pulse, IDLE.

Source files
------------

// File: rtl/vending_machine_pkg.sv
// Shared types and constants for the vending machine credit path.
package vending_machine_pkg;

    localparam int TOTAL_W_DEF = 16;
    localparam int N_COIN_DEF  = 3;
    localparam int N_ITEM_DEF  = 4;

    // Coin values ascending; COIN_VAL[0] is the smallest coin.
    localparam int unsigned COIN_VAL   [N_COIN_DEF] = '{100, 500, 1000};
    localparam int unsigned ITEM_PRICE [N_ITEM_DEF] = '{400, 500, 1000, 2000};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CREDIT = 2'd1,
        RETURN = 2'd2
    } vm_state_e;

endpackage

// File: rtl/vm_change_picker.sv
// Greedy change selector: largest coin whose value fits in the total.
module vm_change_picker
    import vending_machine_pkg::*;
#(
    parameter int TOTAL_W = TOTAL_W_DEF,
    parameter int N_COIN  = N_COIN_DEF
) (
    input  logic [TOTAL_W-1:0] total_i,
    output logic [N_COIN-1:0]  coin_o,
    output logic [TOTAL_W-1:0] value_o
);

    localparam int SW = TOTAL_W + 1;

    // Coins are ascending, so the last one that fits is the largest.
    always_comb begin
        coin_o  = '0;
        value_o = '0;
        for (int i = 0; i < N_COIN; i++) begin
            if (SW'(COIN_VAL[i]) <= {1'b0, total_i}) begin
                coin_o  = N_COIN'(1) << i;
                value_o = TOTAL_W'(COIN_VAL[i]);
            end
        end
    end

endmodule

// File: rtl/vm_credit_ctrl.sv
// Credit controller: coin accept, item dispense, change return with timeout.
module vm_credit_ctrl
    import vending_machine_pkg::*;
#(
    parameter int TOTAL_W = TOTAL_W_DEF,
    parameter int N_COIN  = N_COIN_DEF,
    parameter int N_ITEM  = N_ITEM_DEF,
    parameter int TIMEOUT = 100
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [N_COIN-1:0]  i_coin,
    input  logic [N_ITEM-1:0]  i_select,
    input  logic               i_return,
    output logic [TOTAL_W-1:0] o_total,
    output logic [N_ITEM-1:0]  o_available,
    output logic [N_ITEM-1:0]  o_item,
    output logic [N_COIN-1:0]  o_coin_ret,
    output logic               o_coin_reject,
    output logic               o_busy
);

    localparam int SW    = TOTAL_W + 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(TIMEOUT);
    localparam logic [SW-1:0]    MIN_COIN   = SW'(COIN_VAL[0]);

    vm_state_e          state_q, state_d;
    logic [TOTAL_W-1:0] total_q, total_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_dec;
    logic [N_ITEM-1:0]  item_q, item_d;
    logic [N_COIN-1:0]  coin_ret_q, coin_ret_d;
    logic               reject_q, reject_d;

    logic [N_COIN-1:0]  pick_coin;
    logic [TOTAL_W-1:0] pick_val;
    logic [SW-1:0]      coin_val, sel_price, base, sum, rem;
    logic               dispense, coin_ok;

    vm_change_picker #(.TOTAL_W(TOTAL_W), .N_COIN(N_COIN)) u_picker (
        .total_i (total_q),
        .coin_o  (pick_coin),
        .value_o (pick_val)
    );

    // Decode one-hot strobes into coin value and item price.
    always_comb begin
        coin_val  = '0;
        sel_price = '0;
        for (int i = 0; i < N_COIN; i++)
            if (i_coin[i]) coin_val = SW'(COIN_VAL[i]);
        for (int i = 0; i < N_ITEM; i++)
            if (i_select[i]) sel_price = SW'(ITEM_PRICE[i]);
    end

    // Select is judged on the pre-coin total; overflow on the combined result.
    always_comb begin
        dispense = (state_q == CREDIT) && (|i_select) && ({1'b0, total_q} >= sel_price);
        base     = {1'b0, total_q} - (dispense ? sel_price : '0);
        sum      = base + coin_val;
        coin_ok  = (|i_coin) && !sum[TOTAL_W];
        rem      = {1'b0, total_q} - {1'b0, pick_val};
        cnt_dec  = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);
    end

    // Next-state, total, timeout counter and pulse outputs.
    always_comb begin
        state_d    = state_q;
        total_d    = total_q;
        cnt_d      = cnt_q;
        item_d     = '0;
        coin_ret_d = '0;
        reject_d   = 1'b0;
        case (state_q)
            RETURN: begin
                // One coin per cycle; anything left below the smallest coin stays.
                reject_d   = |i_coin;
                coin_ret_d = pick_coin;
                total_d    = rem[TOTAL_W-1:0];
                if (rem < MIN_COIN) state_d = IDLE;
            end
            default: begin
                if (state_q == CREDIT && i_return) begin
                    state_d = RETURN;
                end else begin
                    reject_d = (|i_coin) && sum[TOTAL_W];
                    item_d   = dispense ? i_select : '0;
                    total_d  = coin_ok ? sum[TOTAL_W-1:0] : base[TOTAL_W-1:0];
                    if (coin_ok || dispense)   cnt_d = CNT_RELOAD;
                    else if (state_q == CREDIT) cnt_d = cnt_dec;
                    if (state_q == IDLE) begin
                        if (coin_ok) state_d = CREDIT;
                    end else if (!coin_ok && !dispense && cnt_dec == '0 && total_d != '0) begin
                        state_d = RETURN;
                    end else if (total_d == '0) begin
                        state_d = IDLE;
                    end
                end
            end
        endcase
    end

    // State and output registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            total_q    <= '0;
            cnt_q      <= CNT_RELOAD;
            item_q     <= '0;
            coin_ret_q <= '0;
            reject_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            total_q    <= total_d;
            cnt_q      <= cnt_d;
            item_q     <= item_d;
            coin_ret_q <= coin_ret_d;
            reject_q   <= reject_d;
        end
    end

    assign o_total       = total_q;
    assign o_item        = item_q;
    assign o_coin_ret    = coin_ret_q;
    assign o_coin_reject = reject_q;
    assign o_busy        = (state_q == RETURN);

    for (genvar k = 0; k < N_ITEM; k++) begin : g_avail
        assign o_available[k] = ({1'b0, total_q} >= SW'(ITEM_PRICE[k]));
    end

endmodule
